conv_window_scheduler: RTL and testbench

- Sequences a frame through the 3x3 sliding-window convolution engine.
- Raster-scans the column memory strip by strip. Each strip is KERNEL_HEIGHT rows tall, and the strip's top row advances by 1 per strip.
- Issues one column read per cycle and tags the engine's output stream with valid, coordinates and a frame-done marker.
- Sits between the frame-start/config interface and the engine and column memory. The engine has no enable input, so the schedule is strictly non-stalling.

---
 rtl/conv_window_scheduler_pkg.sv | 18 +
 rtl/conv_window_scheduler_if.sv | 26 ++
 rtl/conv_window_scheduler_tag_delay.sv | 19 +
 rtl/conv_window_scheduler.sv | 85 ++++++++
 tb/tb_conv_window_scheduler.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_window_scheduler_pkg.sv
// conv_window_scheduler_pkg: shared constants, FSM states and delay-line tag type
package conv_pkg;
    localparam int KERNEL_WIDTH   = 3;
    localparam int KERNEL_HEIGHT  = 3;
    localparam int COORD_WIDTH    = 10;
    localparam int MEM_LATENCY    = 1;
    localparam int ENGINE_LATENCY = 5;
    localparam int TOTAL_LAT      = MEM_LATENCY + ENGINE_LATENCY;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic                   valid;
        logic [COORD_WIDTH-1:0] x;
        logic [COORD_WIDTH-1:0] y;
        logic                   last;
    } tag_t;
endpackage

// File: rtl/conv_window_scheduler_if.sv
// conv_window_scheduler_if: frame-start/config inputs and read/tag outputs of the scheduler
interface conv_window_scheduler_if;
    logic                            start;
    logic [conv_pkg::COORD_WIDTH-1:0] cfg_width;
    logic [conv_pkg::COORD_WIDTH-1:0] cfg_height;
    logic                            busy;
    logic                            cfg_err;
    logic                            col_rd_en;
    logic [conv_pkg::COORD_WIDTH-1:0] col_x;
    logic [conv_pkg::COORD_WIDTH-1:0] strip_y;
    logic                            out_valid;
    logic [conv_pkg::COORD_WIDTH-1:0] out_x;
    logic [conv_pkg::COORD_WIDTH-1:0] out_y;
    logic                            frame_last;
    logic                            done;

    modport master (
        output start, cfg_width, cfg_height,
        input  busy, cfg_err, col_rd_en, col_x, strip_y, out_valid, out_x, out_y, frame_last, done
    );

    modport slave (
        input  start, cfg_width, cfg_height,
        output busy, cfg_err, col_rd_en, col_x, strip_y, out_valid, out_x, out_y, frame_last, done
    );
endinterface

// File: rtl/conv_window_scheduler_tag_delay.sv
// conv_tag_delay: fixed-depth shift register aligning read tags with engine output
module conv_tag_delay
    import conv_pkg::*;
(
    input  logic clk,
    input  logic i_clr,
    input  tag_t i_tag,
    output tag_t o_tag
);
    tag_t [TOTAL_LAT-1:0] r_pipe;

    // shift one tag per cycle; clear drops every in-flight tag
    always_ff @(posedge clk) begin
        if (i_clr) r_pipe <= '0;
        else r_pipe <= {r_pipe[TOTAL_LAT-2:0], i_tag};
    end

    assign o_tag = r_pipe[TOTAL_LAT-1];
endmodule

// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: non-stalling strip raster scan of column reads with output tagging
module conv_window_scheduler
    import conv_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    conv_window_scheduler_if.slave  bus
);
    state_t                 r_state, w_next;
    logic [COORD_WIDTH-1:0] r_w, r_h, r_col_x, r_strip_y;
    logic                   r_cfg_err;
    logic                   w_illegal, w_accept, w_run, w_col_end, w_last_rd, w_tag_ok;
    tag_t                   w_in_tag, w_out_tag;

    assign w_illegal = bus.cfg_width < COORD_WIDTH'(KERNEL_WIDTH) || bus.cfg_height < COORD_WIDTH'(KERNEL_HEIGHT);
    assign w_accept  = r_state == IDLE && bus.start && !w_illegal;
    assign w_run     = r_state == RUN;
    assign w_col_end = r_col_x == r_w - COORD_WIDTH'(1);
    assign w_last_rd = w_col_end && r_strip_y == r_h - COORD_WIDTH'(KERNEL_HEIGHT);
    assign w_tag_ok  = w_run && r_col_x >= COORD_WIDTH'(KERNEL_WIDTH - 1);

    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    // next state: the frame ends once the tag of the last read has left the delay line
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_accept ? RUN : IDLE;
            RUN:     w_next = w_last_rd ? DRAIN : RUN;
            DRAIN:   w_next = w_out_tag.last ? DONE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    // config latch, scan counters and the rejected-start pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_w       <= '0;
            r_h       <= '0;
            r_col_x   <= '0;
            r_strip_y <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= r_state == IDLE && bus.start && w_illegal;
            if (w_accept) begin
                r_w       <= bus.cfg_width;
                r_h       <= bus.cfg_height;
                r_col_x   <= '0;
                r_strip_y <= '0;
            end else if (w_run) begin
                r_col_x   <= w_col_end ? '0 : r_col_x + COORD_WIDTH'(1);
                r_strip_y <= w_col_end ? r_strip_y + COORD_WIDTH'(1) : r_strip_y;
            end
        end
    end

    // outputs and the tag for this cycle's read; stale leading columns get an invalid tag
    always_comb begin
        bus.busy       = w_run || r_state == DRAIN;
        bus.cfg_err    = r_cfg_err;
        bus.col_rd_en  = w_run;
        bus.col_x      = r_col_x;
        bus.strip_y    = r_strip_y;
        bus.done       = r_state == DONE;
        bus.out_valid  = w_out_tag.valid;
        bus.out_x      = w_out_tag.x;
        bus.out_y      = w_out_tag.y;
        bus.frame_last = w_out_tag.last;
        w_in_tag.valid = w_tag_ok;
        w_in_tag.x     = w_tag_ok ? r_col_x - COORD_WIDTH'(KERNEL_WIDTH - 1) : '0;
        w_in_tag.y     = w_tag_ok ? r_strip_y : '0;
        w_in_tag.last  = w_tag_ok && w_last_rd;
    end

    conv_tag_delay u_delay (
        .clk   (clk),
        .i_clr (reset),
        .i_tag (w_in_tag),
        .o_tag (w_out_tag)
    );
endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb_conv_window_scheduler: randomized self-checking bench against a frame-level schedule model
module tb_conv_window_scheduler;
    localparam int KW  = 3;
    localparam int KH  = 3;
    localparam int LAT = 6;

    typedef struct packed {
        int   c;
        int   x;
        int   y;
        logic l;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   busy_n = 0;
    ev_t  rd_q[$];
    ev_t  out_q[$];
    int   done_q[$];
    int   err_q[$];

    conv_window_scheduler_if bus();

    conv_window_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.col_rd_en) rd_q.push_back('{cyc, int'(bus.col_x), int'(bus.strip_y), 1'b0});
        if (bus.out_valid) out_q.push_back('{cyc, int'(bus.out_x), int'(bus.out_y), bus.frame_last});
        if (bus.done) done_q.push_back(cyc);
        if (bus.cfg_err) err_q.push_back(cyc);
        if (bus.busy) busy_n++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        rd_q.delete();
        out_q.delete();
        done_q.delete();
        err_q.delete();
        busy_n = 0;
    endtask

    task automatic wait_done(input int k, input string nm);
        for (int i = 0; i < 3000 && done_q.size() < k; i++) tick();
        checks++;
        if (done_q.size() < k) begin
            errors++;
            $display("FAIL %s timeout: done pulses got %0d want %0d", nm, done_q.size(), k);
        end
    endtask

    task automatic check_frame(input int w, input int h, input int s, input string nm);
        ev_t er[$];
        ev_t eo[$];
        int  n = 0;
        for (int y = 0; y <= h - KH; y++)
            for (int x = 0; x < w; x++) begin
                er.push_back('{s + 1 + n, x, y, 1'b0});
                if (x >= KW - 1) eo.push_back('{s + 1 + n + LAT, x - (KW - 1), y, (y == h - KH && x == w - 1)});
                n++;
            end
        checks++;
        if (rd_q.size() !== er.size()) begin
            errors++;
            $display("FAIL %s read count: got %0d want %0d", nm, rd_q.size(), er.size());
        end
        for (int i = 0; i < er.size() && i < rd_q.size(); i++) begin
            checks++;
            if (rd_q[i] !== er[i]) begin
                errors++;
                $display("FAIL %s read[%0d]: got c=%0d x=%0d y=%0d want c=%0d x=%0d y=%0d", nm, i,
                         rd_q[i].c, rd_q[i].x, rd_q[i].y, er[i].c, er[i].x, er[i].y);
            end
        end
        checks++;
        if (out_q.size() !== eo.size()) begin
            errors++;
            $display("FAIL %s out_valid count: got %0d want %0d", nm, out_q.size(), eo.size());
        end
        for (int i = 0; i < eo.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== eo[i]) begin
                errors++;
                $display("FAIL %s out[%0d]: got c=%0d x=%0d y=%0d last=%0b want c=%0d x=%0d y=%0d last=%0b", nm, i,
                         out_q[i].c, out_q[i].x, out_q[i].y, out_q[i].l, eo[i].c, eo[i].x, eo[i].y, eo[i].l);
            end
        end
        checks++;
        if (done_q.size() !== 1 || done_q[0] !== s + n + LAT + 1) begin
            errors++;
            $display("FAIL %s done: got %0d pulses first at %0d want 1 at %0d", nm, done_q.size(),
                     done_q.size() > 0 ? done_q[0] : -1, s + n + LAT + 1);
        end
        checks++;
        if (busy_n !== n + LAT) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d want %0d", nm, busy_n, n + LAT);
        end
        checks++;
        if (err_q.size() !== 0) begin
            errors++;
            $display("FAIL %s cfg_err on legal frame: got %0d want 0", nm, err_q.size());
        end
    endtask

    task automatic run_frame(input int w, input int h, input string nm);
        int s;
        tick();
        clr();
        s = cyc;
        bus.cfg_width  = 10'(w);
        bus.cfg_height = 10'(h);
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
        bus.cfg_width  = 10'($urandom);
        bus.cfg_height = 10'($urandom);
        wait_done(1, nm);
        tick();
        check_frame(w, h, s, nm);
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.busy, bus.cfg_err, bus.col_rd_en, bus.col_x, bus.strip_y, bus.out_valid,
             bus.out_x, bus.out_y, bus.frame_last, bus.done} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got busy=%0b rd=%0b x=%0d y=%0d ov=%0b done=%0b want all 0",
                     bus.busy, bus.col_rd_en, bus.col_x, bus.strip_y, bus.out_valid, bus.done);
        end
    endtask

    task automatic test_cfg_err(input int w, input int h, input string nm);
        int s;
        tick();
        clr();
        s = cyc;
        bus.cfg_width  = 10'(w);
        bus.cfg_height = 10'(h);
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        checks++;
        if (err_q.size() !== 1 || err_q[0] !== s + 1) begin
            errors++;
            $display("FAIL %s cfg_err: got %0d pulses first at %0d want 1 at %0d", nm, err_q.size(),
                     err_q.size() > 0 ? err_q[0] : -1, s + 1);
        end
        checks++;
        if (rd_q.size() !== 0 || busy_n !== 0) begin
            errors++;
            $display("FAIL %s activity: got reads=%0d busy=%0d want 0 0", nm, rd_q.size(), busy_n);
        end
    endtask

    task automatic test_start_held();
        int s;
        int d;
        int n1;
        tick();
        clr();
        s = cyc;
        bus.cfg_width  = 10'd4;
        bus.cfg_height = 10'd3;
        bus.start      = 1'b1;
        wait_done(1, "held_first");
        d  = done_q.size() > 0 ? done_q[0] : 0;
        n1 = rd_q.size();
        checks++;
        if (n1 !== 4 || d !== s + 4 + LAT + 1 || rd_q[0].c !== s + 1) begin
            errors++;
            $display("FAIL held first frame: got reads=%0d done=%0d want reads=4 done=%0d", n1, d, s + 4 + LAT + 1);
        end
        for (int i = 0; i < 50 && rd_q.size() <= n1; i++) tick();
        checks++;
        if (rd_q.size() <= n1 || rd_q[n1].c !== d + 2) begin
            errors++;
            $display("FAIL held restart: got first read at %0d want %0d", rd_q.size() > n1 ? rd_q[n1].c : -1, d + 2);
        end
        bus.start = 1'b0;
        wait_done(2, "held_second");
        tick();
        checks++;
        if (rd_q.size() !== 8 || out_q.size() !== 4) begin
            errors++;
            $display("FAIL held totals: got reads=%0d outs=%0d want 8 4", rd_q.size(), out_q.size());
        end
    endtask

    task automatic test_reset_mid();
        tick();
        bus.cfg_width  = 10'd5;
        bus.cfg_height = 10'd5;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 200 && !(bus.col_rd_en && bus.strip_y == 1); i++) tick();
        checks++;
        if (!(bus.col_rd_en && bus.strip_y == 1)) begin
            errors++;
            $display("FAIL reset_mid reach strip1: got rd=%0b y=%0d want 1 1", bus.col_rd_en, bus.strip_y);
        end
        reset = 1'b1;
        tick();
        test_reset();
        reset = 1'b0;
        clr();
        repeat (10) tick();
        checks++;
        if (out_q.size() !== 0 || done_q.size() !== 0 || rd_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_mid aftermath: got outs=%0d dones=%0d reads=%0d want 0 0 0",
                     out_q.size(), done_q.size(), rd_q.size());
        end
        run_frame(5, 5, "post_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) run_frame($urandom_range(3, 9), $urandom_range(3, 6), "rand_frame");
        test_cfg_err($urandom_range(0, 2), $urandom_range(3, 20), "rand_bad_w");
        test_cfg_err($urandom_range(3, 20), $urandom_range(0, 2), "rand_bad_h");
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.cfg_width  = '0;
        bus.cfg_height = '0;
        repeat (3) tick();
        test_reset();
        reset = 1'b0;
        run_frame(5, 4, "basic_5x4");
        run_frame(3, 3, "min_3x3");
        test_cfg_err(2, 5, "bad_2x5");
        test_start_held();
        test_reset_mid();
        run_frame(6, 3, "b2b_6x3");
        run_frame(3, 4, "b2b_3x4");
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
